// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port main-memory arbiter: FSM encoding, port ids,
// and the round-robin pick.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    SERVE = 2'd2
  } state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // With both ports pending, the port that did not complete last wins.
  function automatic logic rr_pick(input logic [1:0] cand, input logic last);
    if (cand == 2'b11) return ~last;
    return cand[0] ? PORT_I : PORT_D;
  endfunction

endpackage

// File: rtl/mem_arb_wbuf.sv
// One-entry posted-write buffer: holds a cache's single write-back beat until
// its port is granted and the beat is drained to memory.
module mem_arb_wbuf
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              clr,
  output logic              wb_v,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data
);

  // A capture wins over a same-cycle clear so a fresh beat is never dropped.
  always_ff @(posedge clk) begin
    if (rst)      wb_v <= 1'b0;
    else if (cap) wb_v <= 1'b1;
    else if (clr) wb_v <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (cap) begin
      wb_addr <= addr;
      wb_data <= data;
    end
  end

  // Caches must not post a second write-back before the first one drains.
  a_no_overwrite: assert property (@(posedge clk) disable iff (rst) !(cap && wb_v));

endmodule

// File: rtl/mem_arb_2p.sv
// Round-robin arbiter between I-cache (port 0) and D-cache (port 1) onto one
// main-memory port; write-backs are posted and drained ahead of the refill.
module mem_arb_2p
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_op,
  input  logic              p0_valid,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ready,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_op,
  input  logic              p1_valid,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ready,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              m_op,
  output logic              m_valid,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata
);

  state_e state, state_nxt;
  logic   owner, owner_nxt, last, last_nxt, gnt;

  logic [1:0]             req_v, req_op, cap, clr, wb_v, rdy;
  logic [1:0][ADDR_W-1:0] req_addr, wb_addr;
  logic [1:0][DATA_W-1:0] req_wdata, wb_data, rd;

  assign req_v     = {p1_valid, p0_valid};
  assign req_op    = {p1_op, p0_op};
  assign req_addr  = {p1_addr, p0_addr};
  assign req_wdata = {p1_wdata, p0_wdata};

  // The serving owner's writes go straight to memory; everyone else posts.
  for (genvar n = 0; n < 2; n++) begin : g_port
    assign cap[n] = req_v[n] & ~req_op[n] & ~(state == SERVE && owner == 1'(n));
    assign clr[n] = (state == DRAIN) && (owner == 1'(n));

    mem_arb_wbuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wbuf (
      .clk     (clk),
      .rst     (rst),
      .cap     (cap[n]),
      .addr    (req_addr[n]),
      .data    (req_wdata[n]),
      .clr     (clr[n]),
      .wb_v    (wb_v[n]),
      .wb_addr (wb_addr[n]),
      .wb_data (wb_data[n])
    );
  end

  assign gnt = rr_pick(req_v | wb_v, last);

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    m_valid   = 1'b0;
    m_op      = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    rdy       = '0;
    rd        = '0;
    case (state)
      IDLE: begin
        if (|(req_v | wb_v)) begin
          owner_nxt = gnt;
          state_nxt = (wb_v[gnt] | cap[gnt]) ? DRAIN : SERVE;
        end
      end
      DRAIN: begin
        m_valid   = 1'b1;
        m_addr    = wb_addr[owner];
        m_wdata   = wb_data[owner];
        state_nxt = SERVE;
      end
      SERVE: begin
        m_valid = req_v[owner];
        m_op    = req_op[owner];
        m_addr  = req_addr[owner];
        m_wdata = req_wdata[owner];
        if (!req_v[owner]) begin
          state_nxt = IDLE;
        end else if (req_op[owner] && m_ready) begin
          rdy[owner] = 1'b1;
          rd[owner]  = m_rdata;
          last_nxt   = owner;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= PORT_I;
      last  <= PORT_D;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
    end
  end

  assign p0_ready = rdy[PORT_I];
  assign p1_ready = rdy[PORT_D];
  assign p0_rdata = rd[PORT_I];
  assign p1_rdata = rd[PORT_D];

endmodule

// File: tb/tb_mem_arb_2p.sv
// Bench for mem_arb_2p: directed timing scenarios, then two randomized cache
// agents scored against per-port expected memory-beat and read-data queues.
module tb_mem_arb_2p;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NTX = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          pv[2], pop[2];
  logic [AW-1:0] pa[2];
  logic [DW-1:0] pd[2];
  logic          p0_ready, p1_ready, m_op, m_valid, m_ready;
  logic [DW-1:0] p0_rdata, p1_rdata, m_wdata, m_rdata;
  logic [AW-1:0] m_addr;

  int checks = 0;
  int errors = 0;
  bit sb_on  = 1'b0;

  typedef struct {
    logic          op;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } beat_t;

  beat_t         mq[2][$];
  logic [DW-1:0] rq[2][$];

  always #5 clk = ~clk;

  mem_arb_2p #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .p0_op(pop[0]), .p0_valid(pv[0]), .p0_addr(pa[0]), .p0_wdata(pd[0]),
    .p0_ready(p0_ready), .p0_rdata(p0_rdata),
    .p1_op(pop[1]), .p1_valid(pv[1]), .p1_addr(pa[1]), .p1_wdata(pd[1]),
    .p1_ready(p1_ready), .p1_rdata(p1_rdata),
    .m_op(m_op), .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata)
  );

  function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // Bit 28 identifies the issuing port so the scoreboard can route beats.
  function automatic logic [AW-1:0] rand_addr(input int n);
    logic [31:0] r;
    r = $urandom;
    return {3'b000, 1'(n), 16'h0, r[9:0], 2'b00};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int n, input logic v, input logic op,
                     input logic [AW-1:0] a, input logic [DW-1:0] d);
    pv[n] = v; pop[n] = op; pa[n] = a; pd[n] = d;
  endtask

  task automatic exp_m(input string nm, input logic v, input logic op,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    chk({nm, "_mvalid"}, 64'(m_valid), 64'(v));
    chk({nm, "_mop"},    64'(m_op),    64'(op));
    chk({nm, "_maddr"},  64'(m_addr),  64'(a));
    chk({nm, "_mwdata"}, 64'(m_wdata), 64'(d));
  endtask

  // Call right after exp_m; samples the same negedge.
  task automatic exp_r(input string nm, input logic r0, input logic r1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    chk({nm, "_p0ready"}, 64'(p0_ready), 64'(r0));
    chk({nm, "_p1ready"}, 64'(p1_ready), 64'(r1));
    chk({nm, "_p0rdata"}, 64'(p0_rdata), 64'(d0));
    chk({nm, "_p1rdata"}, 64'(p1_rdata), 64'(d1));
  endtask

  task automatic monitor();
    beat_t         b;
    int            n;
    logic          r;
    logic [DW-1:0] rv;
    forever begin
      @(negedge clk);
      if (sb_on) begin
        for (int p = 0; p < 2; p++) begin
          r  = (p == 0) ? p0_ready : p1_ready;
          rv = (p == 0) ? p0_rdata : p1_rdata;
          if (r) begin
            if (rq[p].size() == 0) begin
              checks++; errors++;
              $display("FAIL sb_ready port %0d got ready exp none pending", p);
            end else chk("sb_rdata", 64'(rv), 64'(rq[p].pop_front()));
          end else chk("sb_rdata_idle", 64'(rv), 64'(0));
        end
        if (m_valid && (!m_op || m_ready)) begin
          n = int'(m_addr[28]);
          if (mq[n].size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_beat addr %0h got beat exp none pending", m_addr);
          end else begin
            b = mq[n].pop_front();
            chk("sb_op",   64'(m_op),   64'(b.op));
            chk("sb_addr", 64'(m_addr), 64'(b.addr));
            if (!b.op) chk("sb_wdata", 64'(m_wdata), 64'(b.data));
          end
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int            phase[2], gap[2], done[2], cyc;
    logic          rdy_s[2];
    logic [AW-1:0] ra[2], wa;
    logic [DW-1:0] wd;

    fork monitor(); join_none
    for (int n = 0; n < 2; n++) drv(n, 0, 0, '0, '0);
    rst = 1'b1; m_ready = 1'b0; m_rdata = '0;
    step(); m_ready = 1'b1; m_rdata = 32'hFFFF_FFFF;
    step();
    exp_m("rst", 0, 0, 0, 0); exp_r("rst", 0, 0, 0, 0);
    step(); rst = 1'b0; m_ready = 1'b0; m_rdata = '0;

    // Lone port-0 refill, memory answers on the third SERVE cycle.
    step(); drv(0, 1, 1, 32'h100, 0);
    exp_m("t1_idle", 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      step();
      if (k == 3) begin m_ready = 1'b1; m_rdata = 32'hDEAD_BEEF; end
      exp_m("t1_serve", 1, 1, 32'h100, 0);
      exp_r("t1_serve", k == 3, 0, (k == 3) ? 32'hDEAD_BEEF : 32'h0, 0);
    end
    step(); pv[0] = 0; m_ready = 0; m_rdata = '0;
    exp_m("t1_end", 0, 0, 0, 0); exp_r("t1_end", 0, 0, 0, 0);

    // Port-1 write-back then refill from IDLE: drain first.
    step(); drv(1, 1, 0, 32'h400, 32'h1234_5678);
    exp_m("t2_idle", 0, 0, 0, 0);
    step(); drv(1, 1, 1, 32'h800, 0);
    exp_m("t2_drain", 1, 0, 32'h400, 32'h1234_5678); exp_r("t2_drain", 0, 0, 0, 0);
    step(); m_ready = 1; m_rdata = 32'hCAFE_F00D;
    exp_m("t2_serve", 1, 1, 32'h800, 0); exp_r("t2_serve", 0, 1, 0, 32'hCAFE_F00D);
    step(); pv[1] = 0; m_ready = 0; m_rdata = '0;
    exp_m("t2_end", 0, 0, 0, 0);

    // Port-1 posts while port 0 is stalled in SERVE.
    step(); drv(0, 1, 1, 32'h2000, 0);
    exp_m("t3_idle", 0, 0, 0, 0);
    step(); drv(1, 1, 0, 32'hC00, 32'hA5A5_A5A5);
    exp_m("t3_hold1", 1, 1, 32'h2000, 0); exp_r("t3_hold1", 0, 0, 0, 0);
    step(); drv(1, 1, 1, 32'h1000, 0);
    exp_m("t3_hold2", 1, 1, 32'h2000, 0);
    step(); m_ready = 1; m_rdata = 32'h1111_2222;
    exp_m("t3_p0done", 1, 1, 32'h2000, 0); exp_r("t3_p0done", 1, 0, 32'h1111_2222, 0);
    step(); pv[0] = 0; m_ready = 0; m_rdata = '0;
    exp_m("t3_gap", 0, 0, 0, 0);
    step();
    exp_m("t3_drain", 1, 0, 32'hC00, 32'hA5A5_A5A5); exp_r("t3_drain", 0, 0, 0, 0);
    step(); m_ready = 1; m_rdata = 32'h3333_4444;
    exp_m("t3_serve", 1, 1, 32'h1000, 0); exp_r("t3_serve", 0, 1, 0, 32'h3333_4444);
    step(); pv[1] = 0; m_ready = 0; m_rdata = '0;
    exp_m("t3_end", 0, 0, 0, 0);

    // Both ports reading continuously with instant memory: strict alternation.
    step(); drv(0, 1, 1, 32'h10, 0); drv(1, 1, 1, 32'h20, 0);
    m_ready = 1; m_rdata = 32'h600D_0000;
    exp_m("t4_idle", 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k % 2 == 1) begin
        exp_m("t4_grant", 1, 1, ((k >> 1) % 2 == 0) ? 32'h10 : 32'h20, 0);
        exp_r("t4_grant", (k >> 1) % 2 == 0, (k >> 1) % 2 == 1,
              ((k >> 1) % 2 == 0) ? 32'h600D_0000 : 32'h0,
              ((k >> 1) % 2 == 1) ? 32'h600D_0000 : 32'h0);
      end else begin
        exp_m("t4_gap", 0, 0, 0, 0); exp_r("t4_gap", 0, 0, 0, 0);
      end
    end
    step(); pv[0] = 0; pv[1] = 0; m_ready = 0; m_rdata = '0;
    exp_m("t4_end", 0, 0, 0, 0);

    // Reset mid-SERVE with a posted port-1 write outstanding.
    step(); drv(0, 1, 1, 32'h3000, 0);
    exp_m("t5_idle", 0, 0, 0, 0);
    step(); drv(1, 1, 0, 32'h5000, 32'h77);
    exp_m("t5_serve", 1, 1, 32'h3000, 0);
    step(); pv[1] = 0; rst = 1;
    step(); rst = 0; pv[0] = 0;
    exp_m("t5_rst", 0, 0, 0, 0); exp_r("t5_rst", 0, 0, 0, 0);
    step(); drv(0, 1, 1, 32'h40, 0); drv(1, 1, 1, 32'h50, 0);
    exp_m("t5_tie_idle", 0, 0, 0, 0);
    step(); m_ready = 1; m_rdata = 32'h4444_0000;
    exp_m("t5_tie", 1, 1, 32'h40, 0); exp_r("t5_tie", 1, 0, 32'h4444_0000, 0);
    step(); pv[0] = 0; m_ready = 0;
    exp_m("t5_gap", 0, 0, 0, 0);
    step(); m_ready = 1; m_rdata = 32'h5555_0000;
    exp_m("t5_nodrain", 1, 1, 32'h50, 0); exp_r("t5_nodrain", 0, 1, 0, 32'h5555_0000);
    step(); pv[1] = 0; m_ready = 0; m_rdata = '0;
    exp_m("t5_end", 0, 0, 0, 0);

    // Owner withdraws in SERVE: back to IDLE, no ready, last untouched.
    step(); drv(0, 1, 1, 32'h70, 0);
    exp_m("t6_idle", 0, 0, 0, 0);
    step();
    exp_m("t6_serve", 1, 1, 32'h70, 0);
    step(); pv[0] = 0;
    exp_m("t6_drop", 0, 1, 32'h70, 0); exp_r("t6_drop", 0, 0, 0, 0);
    step(); drv(0, 1, 1, 32'h80, 0); drv(1, 1, 1, 32'h90, 0); m_ready = 1; m_rdata = 32'h6666_0000;
    exp_m("t6_after", 0, 0, 0, 0);
    step();
    exp_m("t6_tie", 1, 1, 32'h80, 0); exp_r("t6_tie", 1, 0, 32'h6666_0000, 0);
    step(); pv[0] = 0; pv[1] = 0; m_ready = 0; m_rdata = '0;

    // Randomized cache agents: optional write-back beat, then a held refill.
    rst = 1; step(); step(); rst = 0;
    sb_on = 1'b1;
    for (int n = 0; n < 2; n++) begin
      phase[n] = 0; gap[n] = $urandom_range(0, 3); done[n] = 0; rdy_s[n] = 0;
    end
    cyc = 0;
    while ((done[0] < NTX || done[1] < NTX) && cyc < 8000) begin
      step();
      for (int n = 0; n < 2; n++) begin
        case (phase[n])
          0: if (done[n] < NTX) begin
               if (gap[n] > 0) gap[n]--;
               else begin
                 ra[n] = rand_addr(n);
                 if ($urandom_range(0, 1) == 1) begin
                   wa = rand_addr(n); wd = $urandom;
                   drv(n, 1, 0, wa, wd);
                   mq[n].push_back('{op: 1'b0, addr: wa, data: wd});
                   phase[n] = 1;
                 end else begin
                   drv(n, 1, 1, ra[n], 0);
                   mq[n].push_back('{op: 1'b1, addr: ra[n], data: '0});
                   rq[n].push_back(rd_fn(ra[n]));
                   phase[n] = 2;
                 end
               end
             end
          1: begin
               drv(n, 1, 1, ra[n], 0);
               mq[n].push_back('{op: 1'b1, addr: ra[n], data: '0});
               rq[n].push_back(rd_fn(ra[n]));
               phase[n] = 2;
             end
          default: if (rdy_s[n]) begin
               drv(n, 0, 0, '0, '0);
               phase[n] = 0; gap[n] = $urandom_range(0, 3); done[n]++;
             end
        endcase
      end
      #1;
      if (m_valid && m_op) begin
        m_ready = ($urandom_range(0, 2) == 0);
        m_rdata = rd_fn(m_addr);
      end else begin
        m_ready = 1'($urandom_range(0, 1));
        m_rdata = $urandom;
      end
      @(negedge clk);
      rdy_s[0] = p0_ready; rdy_s[1] = p1_ready;
      cyc++;
    end
    if (done[0] < NTX || done[1] < NTX) begin
      checks++; errors++;
      $display("FAIL rand_timeout got %0d/%0d exp %0d each", done[0], done[1], NTX);
    end
    step(); m_ready = 0;
    repeat (3) step();
    chk("left_mq0", 64'(mq[0].size()), 64'(0));
    chk("left_mq1", 64'(mq[1].size()), 64'(0));
    chk("left_rq0", 64'(rq[0].size()), 64'(0));
    chk("left_rq1", 64'(rq[1].size()), 64'(0));
    sb_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
